timeset_controller: RTL and testbench

Upstream front end for basic_clock. It generates the free-running 1 Hz strobe from the system clock. It debounces the raw hour, minute and fast-set buttons. It decodes them into the 2-bit clock mode (0 COUNTING, 1 SET_MINUTES, 2 SET_HOURS, 3 CLEAR_SECONDS) and produces the timeset strobe at a slow or fast rate. Its outputs connect directly to basic_clock's i_1hz_stb, i_timeset_stb and i_mode.

---
 rtl/timeset_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_timeset_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timeset_controller.sv
// ---------------------------------------------------------------------------
// timeset_controller
//
// Front end for basic_clock. It divides the system clock down to a 1 Hz
// strobe, synchronises and debounces the hour, minute and fast-set buttons,
// decodes them into the clock mode and generates the timeset strobe at a slow
// or fast rate.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_btn_hours    raw hour button, active-high, asynchronous
//   i_btn_minutes  raw minute button, active-high, asynchronous
//   i_btn_fast     raw fast-set button, active-high, asynchronous
//   o_1hz_stb      one-cycle pulse once per second
//   o_timeset_stb  one-cycle pulse at the current set rate
//   o_mode         0 COUNTING, 1 SET_MINUTES, 2 SET_HOURS, 3 CLEAR_SECONDS
//
// Optional feature macro: HOLD_ACCEL_EN
//   When defined, holding a set button switches to the fast rate on its own
//   after ACCEL_COUNT slow-rate strobes in the same set state.
// ---------------------------------------------------------------------------
module timeset_controller #(
    parameter int SYS_CLK_HZ      = 50_000_000,
    parameter int FAST_SET_HZ     = 5,
    parameter int SLOW_SET_HZ     = 2,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int ACCEL_COUNT     = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_btn_hours,
    input  logic       i_btn_minutes,
    input  logic       i_btn_fast,
    output logic       o_1hz_stb,
    output logic       o_timeset_stb,
    output logic [1:0] o_mode
);

    localparam int ONE_HZ_DIV  = SYS_CLK_HZ;
    localparam int FAST_DIV    = (FAST_SET_HZ > 0) ? (SYS_CLK_HZ / FAST_SET_HZ) : 0;
    localparam int SLOW_DIV    = (SLOW_SET_HZ > 0) ? (SYS_CLK_HZ / SLOW_SET_HZ) : 0;
    localparam int SET_DIV_MAX = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;

    localparam int ONE_HZ_W = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
    localparam int SET_W    = (SET_DIV_MAX > 1) ? $clog2(SET_DIV_MAX) : 1;
    localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [ONE_HZ_W-1:0] ONE_HZ_LAST = ONE_HZ_W'(ONE_HZ_DIV - 1);
    localparam logic [SET_W-1:0]    FAST_LAST   = SET_W'(FAST_DIV - 1);
    localparam logic [SET_W-1:0]    SLOW_LAST   = SET_W'(SLOW_DIV - 1);
    localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int BTN_HOURS   = 0;
    localparam int BTN_MINUTES = 1;
    localparam int BTN_FAST    = 2;

    // A divisor below 1 would give a zero-length count; refuse to build.
    generate
        if (ONE_HZ_DIV < 1 || FAST_DIV < 1 || SLOW_DIV < 1 ||
            DEBOUNCE_CYCLES < 1 || ACCEL_COUNT < 0) begin : g_bad_config
            $error("timeset_controller: a divisor evaluates to less than 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        COUNTING      = 2'd0,
        SET_MINUTES   = 2'd1,
        SET_HOURS     = 2'd2,
        CLEAR_SECONDS = 2'd3
    } mode_t;

    logic [2:0]      raw;
    logic [2:0]      sync_meta;
    logic [2:0]      sync;
    logic [2:0]      db;
    logic [DB_W-1:0] db_cnt [3];

    mode_t state;
    mode_t state_next;
    mode_t state_prev;

    logic                entry;
    logic                in_set;
    logic                periodic;
    logic                use_fast;
    logic [SET_W-1:0]    set_last;
    logic [SET_W-1:0]    set_cnt;
    logic [ONE_HZ_W-1:0] hz_cnt;

    assign raw = {i_btn_fast, i_btn_minutes, i_btn_hours};

    // Two-flop synchroniser for all three buttons.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Debounce: a button's level only flips after the synchronised value has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreement
    // restarts the count, so short glitches are discarded.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int b = 0; b < 3; b++) begin
                db_cnt[b] <= '0;
            end
            db <= '0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (sync[b] == db[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    db[b]     <= sync[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    // Mode state register; state_prev lets the strobe logic spot the first
    // cycle of a newly entered mode.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= COUNTING;
            state_prev <= COUNTING;
        end else begin
            state      <= state_next;
            state_prev <= state;
        end
    end

    // Mode decode from debounced levels. CLEAR_SECONDS is sticky until both
    // buttons are up so that releasing them one at a time never lands in a
    // set mode by accident.
    always_comb begin
        state_next = state;
        case (state)
            COUNTING: begin
                if (db[BTN_HOURS] && db[BTN_MINUTES]) begin
                    state_next = CLEAR_SECONDS;
                end else if (db[BTN_HOURS]) begin
                    state_next = SET_HOURS;
                end else if (db[BTN_MINUTES]) begin
                    state_next = SET_MINUTES;
                end
            end
            SET_MINUTES: begin
                if (db[BTN_HOURS]) begin
                    state_next = CLEAR_SECONDS;
                end else if (!db[BTN_MINUTES]) begin
                    state_next = COUNTING;
                end
            end
            SET_HOURS: begin
                if (db[BTN_MINUTES]) begin
                    state_next = CLEAR_SECONDS;
                end else if (!db[BTN_HOURS]) begin
                    state_next = COUNTING;
                end
            end
            CLEAR_SECONDS: begin
                if (!db[BTN_HOURS] && !db[BTN_MINUTES]) begin
                    state_next = COUNTING;
                end
            end
            default: state_next = COUNTING;
        endcase
    end

    assign o_mode = state;

    // 1 Hz prescaler. Holding it at zero during CLEAR_SECONDS makes the
    // first second after the clear a full one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hz_cnt <= '0;
        end else if (state == CLEAR_SECONDS || hz_cnt == ONE_HZ_LAST) begin
            hz_cnt <= '0;
        end else begin
            hz_cnt <= hz_cnt + ONE_HZ_W'(1);
        end
    end

    assign o_1hz_stb = (hz_cnt == ONE_HZ_LAST) && (state != CLEAR_SECONDS);

    assign entry    = (state != state_prev) && (state != COUNTING);
    assign in_set   = (state == SET_MINUTES) || (state == SET_HOURS);
    assign set_last = use_fast ? FAST_LAST : SLOW_LAST;
    // ">=" rather than "==" so a drop from slow to fast divisor mid-count
    // fires at once instead of running past the new limit.
    assign periodic = in_set && !entry && (set_cnt >= set_last);

    assign o_timeset_stb = entry || periodic;

    // Set-rate counter: restarts on every strobe, idles outside set modes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            set_cnt <= '0;
        end else if (!in_set || entry || periodic) begin
            set_cnt <= '0;
        end else begin
            set_cnt <= set_cnt + SET_W'(1);
        end
    end

`ifdef HOLD_ACCEL_EN
    localparam int ACCEL_W = (ACCEL_COUNT > 0) ? $clog2(ACCEL_COUNT + 1) : 1;
    localparam logic [ACCEL_W-1:0] ACCEL_SAT = ACCEL_W'(ACCEL_COUNT);

    logic [ACCEL_W-1:0] accel_cnt;
    logic               accel_sat;

    assign accel_sat = (accel_cnt == ACCEL_SAT);
    assign use_fast  = db[BTN_FAST] || accel_sat;

    // Counts periodic strobes issued at the slow rate within one set mode;
    // the entry strobe is excluded and any mode change starts over.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            accel_cnt <= '0;
        end else if (!in_set || entry) begin
            accel_cnt <= '0;
        end else if (periodic && !use_fast) begin
            accel_cnt <= accel_cnt + ACCEL_W'(1);
        end
    end
`else
    assign use_fast = db[BTN_FAST];
`endif

endmodule

// File: tb/tb_timeset_controller.sv
// ---------------------------------------------------------------------------
// tb_timeset_controller
//
// Randomised bench for timeset_controller. Button waveforms are built from
// held segments and short glitches. A reference model derives, from the
// button levels as the user intended them, the cycle of every mode change,
// 1 Hz strobe and timeset strobe, and queues them; a monitor compares the
// DUT against those queues cycle by cycle. An asynchronous reset during a
// set-mode entry strobe closes the run.
// ---------------------------------------------------------------------------
module tb_timeset_controller;

    localparam int SYS_CLK_HZ      = 100;
    localparam int FAST_SET_HZ     = 10;
    localparam int SLOW_SET_HZ     = 5;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int ACCEL_COUNT     = 3;

    localparam int FAST_DIV   = SYS_CLK_HZ / FAST_SET_HZ;
    localparam int SLOW_DIV   = SYS_CLK_HZ / SLOW_SET_HZ;
    localparam int DB_LATENCY = DEBOUNCE_CYCLES + 2;
    localparam int SEGMENTS   = 110;

    localparam int MODE_COUNTING = 0;
    localparam int MODE_SET_MIN  = 1;
    localparam int MODE_SET_HR   = 2;
    localparam int MODE_CLEAR    = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_hours = 1'b0;
    logic       btn_minutes = 1'b0;
    logic       btn_fast = 1'b0;
    logic       stb_1hz;
    logic       stb_timeset;
    logic [1:0] mode;

    timeset_controller #(
        .SYS_CLK_HZ      (SYS_CLK_HZ),
        .FAST_SET_HZ     (FAST_SET_HZ),
        .SLOW_SET_HZ     (SLOW_SET_HZ),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACCEL_COUNT     (ACCEL_COUNT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_btn_hours   (btn_hours),
        .i_btn_minutes (btn_minutes),
        .i_btn_fast    (btn_fast),
        .o_1hz_stb     (stb_1hz),
        .o_timeset_stb (stb_timeset),
        .o_mode        (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int mode;
    } mode_event_t;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          drive_cycle = 0;
    bit          monitor_on = 1'b0;
    int          exp_mode = MODE_COUNTING;

    int          hz_queue [$];
    int          ts_queue [$];
    mode_event_t mode_queue [$];

    // Reference model state: mode and debounced levels of the previous
    // cycle, start cycle of the current second, last timeset strobe cycle,
    // and slow strobes seen in the current set mode.
    int m_mode = MODE_COUNTING;
    bit m_db_h = 1'b0;
    bit m_db_m = 1'b0;
    int m_second_start = 0;
    int m_last_pulse = 0;
    int m_slow_pulses = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
        end
    endtask

    function automatic int next_mode(input int cur, input bit h, input bit m);
        case (cur)
            MODE_COUNTING: return (h && m) ? MODE_CLEAR : (h ? MODE_SET_HR : (m ? MODE_SET_MIN : MODE_COUNTING));
            MODE_SET_MIN:  return h ? MODE_CLEAR : (m ? MODE_SET_MIN : MODE_COUNTING);
            MODE_SET_HR:   return m ? MODE_CLEAR : (h ? MODE_SET_HR : MODE_COUNTING);
            default:       return (!h && !m) ? MODE_COUNTING : MODE_CLEAR;
        endcase
    endfunction

    // Expected behaviour at cycle t, given the debounced levels at t (the
    // intended button levels DB_LATENCY cycles earlier).
    task automatic model_step(input int t, input bit db_h, input bit db_m, input bit db_f);
        int  new_mode;
        int  div;
        bit  fast;
        new_mode = next_mode(m_mode, m_db_h, m_db_m);
        if (t == 0) begin
            m_second_start = 0;
        end else if (m_mode == MODE_CLEAR) begin
            m_second_start = t;
        end
        if (new_mode != MODE_CLEAR && ((t - m_second_start) % SYS_CLK_HZ) == SYS_CLK_HZ - 1) begin
            hz_queue.push_back(t);
        end
        if (new_mode != m_mode) begin
            mode_queue.push_back('{t, new_mode});
        end
        if (new_mode != MODE_COUNTING && new_mode != m_mode) begin
            ts_queue.push_back(t);
            m_last_pulse  = t;
            m_slow_pulses = 0;
        end else if (new_mode == MODE_SET_MIN || new_mode == MODE_SET_HR) begin
            fast = db_f;
`ifdef HOLD_ACCEL_EN
            if (m_slow_pulses >= ACCEL_COUNT) begin
                fast = 1'b1;
            end
`endif
            div = fast ? FAST_DIV : SLOW_DIV;
            if (t - m_last_pulse >= div) begin
                ts_queue.push_back(t);
                m_last_pulse = t;
                if (!fast) begin
                    m_slow_pulses++;
                end
            end
        end
        m_mode = new_mode;
        m_db_h = db_h;
        m_db_m = db_m;
    endtask

    // Drives one cycle of raw button levels ({fast, minutes, hours}) and
    // tells the model the intended (glitch-free) levels for that cycle.
    task automatic apply_stimulus(input logic [2:0] raw, input logic [2:0] nominal);
        btn_hours   = raw[0];
        btn_minutes = raw[1];
        btn_fast    = raw[2];
        model_step(drive_cycle + DB_LATENCY, nominal[0], nominal[1], nominal[2]);
        drive_cycle++;
        @(negedge clk);
    endtask

    task automatic monitor_cycle(input int t);
        bit          exp_pulse;
        mode_event_t ev;
        exp_pulse = (hz_queue.size() > 0 && hz_queue[0] == t);
        if (exp_pulse) begin
            void'(hz_queue.pop_front());
        end
        if (exp_pulse || stb_1hz) begin
            check_output("one_hz_stb", int'(stb_1hz), int'(exp_pulse));
        end
        exp_pulse = (ts_queue.size() > 0 && ts_queue[0] == t);
        if (exp_pulse) begin
            void'(ts_queue.pop_front());
        end
        if (exp_pulse || stb_timeset) begin
            check_output("timeset_stb", int'(stb_timeset), int'(exp_pulse));
        end
        if (mode_queue.size() > 0 && mode_queue[0].cyc == t) begin
            ev = mode_queue.pop_front();
            exp_mode = ev.mode;
            check_output("mode_change", int'(mode), exp_mode);
        end else if (int'(mode) != exp_mode) begin
            check_output("mode_hold", int'(mode), exp_mode);
        end
    endtask

    // Scoreboard monitor: samples just after each rising edge.
    always @(posedge clk) begin
        if (monitor_on) begin
            #2;
            cycle++;
            monitor_cycle(cycle);
        end
    end

    initial begin
        logic [2:0] nominal;
        logic [2:0] raw;
        int         len;
        int         which;
        int         glen;
        int         press_cycle;
        int         guard;

        nominal = 3'b000;

        // Outputs must stay quiet in reset whatever the buttons do.
        repeat (3) @(negedge clk);
        btn_hours   = 1'b1;
        btn_minutes = 1'b1;
        btn_fast    = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_mode", int'(mode), MODE_COUNTING);
        check_output("reset_one_hz", int'(stb_1hz), 0);
        check_output("reset_timeset", int'(stb_timeset), 0);
        btn_hours   = 1'b0;
        btn_minutes = 1'b0;
        btn_fast    = 1'b0;
        @(negedge clk);

        // Cycles before any driven level reaches the debounced outputs.
        for (int t = 0; t < DB_LATENCY; t++) begin
            model_step(t, 1'b0, 1'b0, 1'b0);
        end
        reset_n    = 1'b1;
        monitor_on = 1'b1;

        // Idle long enough to see a few plain seconds.
        repeat (3 * SYS_CLK_HZ + 10) apply_stimulus(3'b000, 3'b000);

        for (int s = 0; s < SEGMENTS; s++) begin
            len = $urandom_range(90, DEBOUNCE_CYCLES + 1);
            if ($urandom_range(3, 0) == 0) begin
                which = $urandom_range(2, 0);
                glen  = $urandom_range(DEBOUNCE_CYCLES - 1, 1);
                raw   = nominal;
                raw[which] = ~nominal[which];
                repeat (glen) apply_stimulus(raw, nominal);
            end else begin
                for (int b = 0; b < 3; b++) begin
                    if ($urandom_range(2, 0) == 0) begin
                        nominal[b] = ~nominal[b];
                    end
                end
            end
            repeat (len) apply_stimulus(nominal, nominal);
        end

        // Return to COUNTING, then press hours and hit reset during the
        // entry strobe of SET_HOURS.
        nominal = 3'b000;
        repeat (3 * DB_LATENCY) apply_stimulus(nominal, nominal);
        press_cycle = drive_cycle;
        nominal = 3'b001;
        apply_stimulus(nominal, nominal);
        guard = 0;
        while (cycle < press_cycle + DB_LATENCY + 1 && guard < 50) begin
            apply_stimulus(nominal, nominal);
            guard++;
        end
        monitor_on = 1'b0;
        check_output("pre_reset_mode", int'(mode), MODE_SET_HR);
        check_output("pre_reset_timeset", int'(stb_timeset), 1);
        reset_n = 1'b0;
        #1;
        check_output("async_reset_mode", int'(mode), MODE_COUNTING);
        check_output("async_reset_one_hz", int'(stb_1hz), 0);
        check_output("async_reset_timeset", int'(stb_timeset), 0);

        $display("[TB] %0d cycles driven", drive_cycle);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
